// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: single-cycle MIPS-subset processor.
//   clk : sole clock, all state updates on the rising edge
//   rst : synchronous active-high reset (PC <= TEXT_BASE, register file cleared)
// Instructions: add/sub/and/or/slt (R-type), addi, lw, sw, beq, j.
// Optional macro BNE_ORI_EN adds bne and ori; without it both opcodes are NOPs.
// Unrecognised encodings behave as NOPs. Out-of-range fetch/data accesses
// read 0 and never write.

module single_cycle_cpu_imem #(
  parameter int unsigned WORDS = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [31:0] raddr,
  output logic [31:0] rdata
);
  localparam int unsigned AW = $clog2(WORDS);

  logic [31:0] insMem [0:WORDS-1];

  // Write port exists only so an external loader can fill the memory;
  // the core ties it off.
  always_ff @(posedge clk) begin
    if (we && (waddr < WORDS)) insMem[waddr[AW-1:0]] <= wdata;
  end

  assign rdata = (raddr < WORDS) ? insMem[raddr[AW-1:0]] : '0;
endmodule

module single_cycle_cpu_dmem #(
  parameter int unsigned WORDS = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int unsigned AW = $clog2(WORDS);

  logic [31:0] dataMem [0:WORDS-1];
  logic        in_range;

  assign in_range = (addr < WORDS);
  assign rdata    = in_range ? dataMem[addr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (we && in_range) dataMem[addr[AW-1:0]] <= wdata;
  end
endmodule

module single_cycle_cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] rf [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
endmodule

module single_cycle_cpu #(
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter logic [31:0] DATA_BASE  = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef BNE_ORI_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ORI   = 6'h0D;
`endif
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic [31:0] PC;
  logic [31:0] inst;
  logic [31:0] pc_next, pc_plus4, br_target, jump_target;
  logic [31:0] imem_word, dmem_word;
  logic [31:0] rs_val, rt_val, sext_imm, mem_addr, dmem_rdata;
  logic [31:0] reg_wd;
  logic [4:0]  reg_wa;
  logic        reg_we, mem_we;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;

  assign imem_word = (PC - TEXT_BASE) >> 2;

  single_cycle_cpu_imem #(.WORDS(IMEM_WORDS)) insMem (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (imem_word),
    .rdata (inst)
  );

  assign op       = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign funct    = inst[5:0];
  assign sext_imm = {{16{inst[15]}}, inst[15:0]};

  single_cycle_cpu_regfile regFile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (reg_we),
    .wa  (reg_wa),
    .wd  (reg_wd)
  );

  assign mem_addr  = rs_val + sext_imm;
  assign dmem_word = (mem_addr - DATA_BASE) >> 2;

  single_cycle_cpu_dmem #(.WORDS(DMEM_WORDS)) dataMem (
    .clk   (clk),
    .we    (mem_we && !rst),
    .addr  (dmem_word),
    .wdata (rt_val),
    .rdata (dmem_rdata)
  );

  assign pc_plus4    = PC + 32'd4;
  assign br_target   = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jump_target = {pc_plus4[31:28], inst[25:0], 2'b00};

  always_comb begin
    reg_we  = 1'b0;
    reg_wa  = rt;
    reg_wd  = '0;
    mem_we  = 1'b0;
    pc_next = pc_plus4;
    case (op)
      OP_RTYPE: begin
        reg_wa = rd;
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  reg_wd = rs_val + rt_val;
          FN_SUB:  reg_wd = rs_val - rt_val;
          FN_AND:  reg_wd = rs_val & rt_val;
          FN_OR:   reg_wd = rs_val | rt_val;
          FN_SLT:  reg_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_we = 1'b1;
        reg_wd = rs_val + sext_imm;
      end
      OP_LW: begin
        reg_we = 1'b1;
        reg_wd = dmem_rdata;
      end
      OP_SW:  mem_we = 1'b1;
      OP_BEQ: if (rs_val == rt_val) pc_next = br_target;
      OP_J:   pc_next = jump_target;
`ifdef BNE_ORI_EN
      OP_BNE: if (rs_val != rt_val) pc_next = br_target;
      OP_ORI: begin
        reg_we = 1'b1;
        reg_wd = rs_val | {16'd0, inst[15:0]};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) PC <= TEXT_BASE;
    else     PC <= pc_next;
  end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: loads a directed program, queues expected
// architectural state tagged by (reset run, cycle), and a monitor pops and
// compares the entries as the core reaches each cycle.
module tb_single_cycle_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;

  single_cycle_cpu #(
    .TEXT_BASE  (32'h0000_3000),
    .DATA_BASE  (32'h0000_0000),
    .IMEM_WORDS (1024),
    .DMEM_WORDS (1024)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  localparam int K_PC = 0, K_REG = 1, K_DMEM = 2, K_INST = 3;

  typedef struct {
    int          run;
    int          cyc;
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          run = 0;
  int          cyc = 0;
  logic        prev_rst = 1'b0;
  logic [31:0] prog [0:23];

`ifdef BNE_ORI_EN
  localparam bit OPT = 1'b1;
`else
  localparam bit OPT = 1'b0;
`endif

  function automatic logic [31:0] r_op(int s, int t, int d, logic [5:0] fn);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(logic [5:0] op, int s, int t, logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction

  function automatic logic [31:0] j_op(logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  function automatic void expect_at(int r, int c, string n, int k, int i, logic [31:0] e);
    exp_t x;
    x.run = r; x.cyc = c; x.name = n; x.kind = k; x.idx = i; x.exp = e;
    sb.push_back(x);
  endfunction

  function automatic logic [31:0] actual(int k, int i);
    case (k)
      K_PC:    return dut.PC;
      K_REG:   return dut.regFile.rf[i];
      K_DMEM:  return dut.dataMem.dataMem[i];
      default: return dut.inst;
    endcase
  endfunction

  // Monitor: track reset runs and cycles, compare due entries at negedge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        if (!prev_rst) run++;
        cyc = 0;
      end else begin
        cyc++;
      end
      prev_rst = rst;
      @(negedge clk);
      while (sb.size() > 0 &&
             (sb[0].run < run || (sb[0].run == run && sb[0].cyc <= cyc))) begin
        exp_t    x;
        logic [31:0] a;
        x = sb.pop_front();
        checks++;
        if (x.run != run || x.cyc != cyc) begin
          failures++;
          $display("FAIL %s missed: due run %0d cyc %0d, now run %0d cyc %0d",
                   x.name, x.run, x.cyc, run, cyc);
        end else begin
          a = actual(x.kind, x.idx);
          if (a !== x.exp) begin
            failures++;
            $display("FAIL %s run %0d cyc %0d: got %h expected %h",
                     x.name, run, cyc, a, x.exp);
          end
        end
      end
    end
  end

  initial begin
    prog[0]  = i_op(6'h08, 0, 1, 16'd5);        // addi $1,$0,5
    prog[1]  = i_op(6'h08, 0, 2, 16'hFFFD);     // addi $2,$0,-3
    prog[2]  = r_op(1, 2, 3, 6'h20);            // add  $3,$1,$2
    prog[3]  = r_op(1, 2, 4, 6'h22);            // sub  $4,$1,$2
    prog[4]  = r_op(2, 1, 5, 6'h2A);            // slt  $5,$2,$1
    prog[5]  = i_op(6'h2B, 0, 3, 16'd80);       // sw   $3,80($0)
    prog[6]  = i_op(6'h2B, 0, 4, 16'd84);       // sw   $4,84($0)
    prog[7]  = i_op(6'h23, 0, 6, 16'd80);       // lw   $6,80($0)
    prog[8]  = i_op(6'h08, 0, 8, 16'h0F0F);     // addi $8,$0,0x0F0F
    prog[9]  = i_op(6'h08, 0, 9, 16'h00FF);     // addi $9,$0,0x00FF
    prog[10] = r_op(8, 9, 10, 6'h24);           // and  $10,$8,$9
    prog[11] = r_op(8, 9, 11, 6'h25);           // or   $11,$8,$9
    prog[12] = i_op(6'h08, 0, 0, 16'd7);        // addi $0,$0,7
    prog[13] = i_op(6'h08, 0, 12, 16'd3);       // addi $12,$0,3
    prog[14] = i_op(6'h08, 13, 13, 16'd1);      // loop: addi $13,$13,1
    prog[15] = i_op(6'h08, 12, 12, 16'hFFFF);   // addi $12,$12,-1
    prog[16] = i_op(6'h04, 12, 0, 16'd1);       // beq  $12,$0,+1
    prog[17] = j_op(26'h0000C0E);               // j    0x3038
    prog[18] = i_op(6'h0D, 0, 7, 16'h8000);     // ori  $7,$0,0x8000
    prog[19] = i_op(6'h05, 1, 0, 16'hFFFF);     // bne  $1,$0,-1
    prog[20] = i_op(6'h08, 0, 15, 16'd1);       // addi $15,$0,1
    prog[21] = i_op(6'h23, 0, 15, 16'h1000);    // lw   $15,4096($0) (out of range)
    prog[22] = r_op(1, 1, 16, 6'h21);           // unknown funct -> NOP
    prog[23] = j_op(26'h0000C17);               // j    0x305C (self)

    for (int i = 0; i < 1024; i++) begin
      dut.insMem.insMem[i]   = '0;
      dut.dataMem.dataMem[i] = '0;
    end
    for (int i = 0; i < 24; i++) dut.insMem.insMem[i] = prog[i];

    expect_at(1, 0,  "pc_reset",     K_PC,   0,  32'h0000_3000);
    expect_at(1, 0,  "inst_first",   K_INST, 0,  prog[0]);
    expect_at(1, 0,  "r1_reset",     K_REG,  1,  32'h0);
    expect_at(1, 0,  "r31_reset",    K_REG,  31, 32'h0);
    expect_at(1, 1,  "r1_addi",      K_REG,  1,  32'd5);
    expect_at(1, 1,  "pc_plus4",     K_PC,   0,  32'h0000_3004);
    expect_at(1, 2,  "r2_addi_neg",  K_REG,  2,  32'hFFFF_FFFD);
    expect_at(1, 5,  "r3_add",       K_REG,  3,  32'd2);
    expect_at(1, 5,  "r4_sub",       K_REG,  4,  32'd8);
    expect_at(1, 5,  "r5_slt",       K_REG,  5,  32'd1);
    expect_at(1, 7,  "dmem20_sw",    K_DMEM, 20, 32'd2);
    expect_at(1, 7,  "dmem21_sw",    K_DMEM, 21, 32'd8);
    expect_at(1, 8,  "r6_lw",        K_REG,  6,  32'd2);
    expect_at(1, 12, "r10_and",      K_REG,  10, 32'h0000_000F);
    expect_at(1, 12, "r11_or",       K_REG,  11, 32'h0000_0FFF);
    expect_at(1, 13, "r0_const",     K_REG,  0,  32'h0);
    expect_at(1, 17, "pc_beq_nt",    K_PC,   0,  32'h0000_3044);
    expect_at(1, 17, "r13_iter1",    K_REG,  13, 32'd1);
    expect_at(1, 17, "r12_iter1",    K_REG,  12, 32'd2);
    expect_at(1, 18, "pc_jump",      K_PC,   0,  32'h0000_3038);
    expect_at(1, 25, "pc_loop_exit", K_PC,   0,  32'h0000_3048);
    expect_at(1, 25, "r13_body_cnt", K_REG,  13, 32'd3);
    expect_at(1, 25, "r12_done",     K_REG,  12, 32'd0);
    expect_at(1, 26, "r7_ori",       K_REG,  7,  OPT ? 32'h0000_8000 : 32'h0);
    expect_at(1, 27, "pc_bne",       K_PC,   0,  OPT ? 32'h0000_304C : 32'h0000_3050);
    expect_at(1, 28, "r15_pre",      K_REG,  15, OPT ? 32'h0 : 32'd1);
    expect_at(1, 29, "r15_lw_oor",   K_REG,  15, 32'h0);
    expect_at(1, 30, "r16_bad_fn",   K_REG,  16, 32'h0);
    expect_at(1, 35, "pc_park",      K_PC,   0,  OPT ? 32'h0000_304C : 32'h0000_305C);
    expect_at(2, 0,  "pc_rst2",      K_PC,   0,  32'h0000_3000);
    expect_at(2, 0,  "r1_rst2",      K_REG,  1,  32'h0);
    expect_at(2, 0,  "r11_rst2",     K_REG,  11, 32'h0);
    expect_at(2, 1,  "r1_rerun",     K_REG,  1,  32'd5);
    expect_at(3, 0,  "pc_rst3",      K_PC,   0,  32'h0000_3000);
    expect_at(3, 0,  "dmem20_abort", K_DMEM, 20, 32'hDEAD_BEEF);
    expect_at(3, 0,  "r4_rst3",      K_REG,  4,  32'h0);
    expect_at(3, 1,  "pc_rst3_1",    K_PC,   0,  32'h0000_3004);
    expect_at(3, 7,  "dmem20_rerun", K_DMEM, 20, 32'd2);

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    dut.dataMem.dataMem[20] = 32'hDEAD_BEEF;
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;                     // aborts the pending sw $3,80($0)
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s never reached: due run %0d cyc %0d", x.name, x.run, x.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
